// File: rtl/hb_decim_seq.sv
// hb_decim_seq -- read/write sequencer for a halfband decimate-by-2 filter
// built around the ram16_2sum dual-read RAM with its registered pre-adder.
//
// Incoming samples are written into the 16-entry RAM circularly. Every second
// sample starts a read sequence. The sequence issues NPAIRS symmetric address
// pairs and then one centre-tap read, where both addresses are equal. The
// coefficient index and the accumulator controls are delayed by 2 cycles so
// that they line up with the pre-adder output. strobe_out marks the cycle
// after the last accumulate.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   enable              low forces IDLE, flushes the pipeline, blocks writes
//   strobe_in, data_in  one-cycle input sample valid and signed sample
//   write, wr_addr,     RAM write port (write and wr_data are combinational)
//   wr_data
//   rd_addr1, rd_addr2  RAM read addresses; they hold their value in IDLE
//   coeff_idx           tap index of the sum at the pre-adder output
//                       (NPAIRS selects the centre tap)
//   acc_en, acc_first,  accumulator controls
//   acc_last
//   strobe_out          decimated result is ready in the accumulator
//   busy                a read sequence is being issued
//   overrun_clr,        only when HB_DECIM_SEQ_OVERRUN_EN is defined: sticky
//   overrun             flag for a dropped trigger and its clear input
//
// Optional feature macro: HB_DECIM_SEQ_OVERRUN_EN
//
// state | meaning
// IDLE  | waiting for a trigger write (a write while phase is 1)
// RUN   | issuing read step step_q; step NPAIRS is the centre tap

module hb_decim_seq #(
  parameter int NPAIRS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        strobe_in,
  input  logic [15:0] data_in,
  output logic        write,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [3:0]  rd_addr1,
  output logic [3:0]  rd_addr2,
  output logic [2:0]  coeff_idx,
  output logic        acc_en,
  output logic        acc_first,
  output logic        acc_last,
  output logic        strobe_out,
`ifdef HB_DECIM_SEQ_OVERRUN_EN
  input  logic        overrun_clr,
  output logic        overrun,
`endif
  output logic        busy
);

  localparam logic [3:0] SPAN = 4'(4 * NPAIRS - 2);
  localparam logic [3:0] HALF = 4'(2 * NPAIRS - 1);
  localparam logic [2:0] LAST = 3'(NPAIRS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [3:0] base_q, base_d;
  logic [3:0] ptr_q, ptr_d;
  logic       phase_q, phase_d;
  logic [3:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic       start, trigger, issue;

  // Two-stage alignment pipeline: RAM register, then pre-adder sum register.
  logic       v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, strobe_q;
  logic [2:0] k1_q, k2_q;

  assign write   = strobe_in & enable;
  assign wr_addr = ptr_q;
  assign wr_data = data_in;
  assign trigger = write & phase_q;
  assign issue   = enable && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    base_d  = base_q;
    ptr_d   = ptr_q;
    phase_d = phase_q;
    start   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      step_d  = '0;
      phase_d = 1'b0;
    end else begin
      if (write) begin
        ptr_d   = ptr_q + 4'd1;
        phase_d = ~phase_q;
      end
      case (state_q)
        IDLE: start = trigger;
        RUN: begin
          // A trigger that arrives on the centre step chains straight into
          // the next sequence. An earlier trigger is dropped.
          if (step_q == LAST) begin
            start = trigger;
            if (!trigger) state_d = IDLE;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        state_d = RUN;
        step_d  = '0;
        base_d  = wr_addr;
      end
    end
  end

  // The read addresses are registered so that step k is on the bus in the
  // cycle where step_q == k. They hold their value outside RUN.
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (state_d == RUN) begin
      if (step_d == LAST) begin
        rd1_d = base_d - HALF;
        rd2_d = base_d - HALF;
      end else begin
        rd1_d = base_d - {step_d, 1'b0};
        rd2_d = base_d - (SPAN - {step_d, 1'b0});
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      base_q   <= '0;
      ptr_q    <= '0;
      phase_q  <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      v1_q     <= 1'b0;
      f1_q     <= 1'b0;
      l1_q     <= 1'b0;
      k1_q     <= '0;
      v2_q     <= 1'b0;
      f2_q     <= 1'b0;
      l2_q     <= 1'b0;
      k2_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      base_q   <= base_d;
      ptr_q    <= ptr_d;
      phase_q  <= phase_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      v1_q     <= issue;
      f1_q     <= issue && (step_q == 3'd0);
      l1_q     <= issue && (step_q == LAST);
      k1_q     <= issue ? step_q : 3'd0;
      v2_q     <= enable & v1_q;
      f2_q     <= enable & f1_q;
      l2_q     <= enable & l1_q;
      k2_q     <= enable ? k1_q : 3'd0;
      strobe_q <= enable & l2_q;
    end
  end

  assign rd_addr1   = rd1_q;
  assign rd_addr2   = rd2_q;
  assign coeff_idx  = k2_q;
  assign acc_en     = v2_q;
  assign acc_first  = f2_q;
  assign acc_last   = l2_q;
  assign strobe_out = strobe_q;
  assign busy       = (state_q == RUN);

`ifdef HB_DECIM_SEQ_OVERRUN_EN
  logic overrun_q, overrun_d, drop;

  assign drop = trigger && (state_q == RUN) && (step_q != LAST);

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_hb_decim_seq.sv
// Directed testbench for hb_decim_seq with the default NPAIRS = 4.
// Outputs are logged on every falling edge, indexed by cycle number, and the
// scenario tasks compare the log against hand-derived timelines.
// For a trigger write in cycle T: t0 = T+1, reads are issued on t0..t0+4,
// acc_en is high on t0+2..t0+6, and strobe_out pulses on t0+7.

module tb_hb_decim_seq;

  localparam int LOGN = 4096;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        strobe_in;
  logic [15:0] data_in;
  logic        write;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [2:0]  coeff_idx;
  logic        acc_en;
  logic        acc_first;
  logic        acc_last;
  logic        strobe_out;
  logic        busy;
`ifdef HB_DECIM_SEQ_OVERRUN_EN
  logic        overrun_clr;
  logic        overrun;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       ae_log[LOGN];
  logic       af_log[LOGN];
  logic       al_log[LOGN];
  logic       so_log[LOGN];
  logic       busy_log[LOGN];
  logic [2:0] cf_log[LOGN];
  logic [3:0] r1_log[LOGN];
  logic [3:0] r2_log[LOGN];

  hb_decim_seq #(.NPAIRS(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .strobe_in  (strobe_in),
    .data_in    (data_in),
    .write      (write),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .coeff_idx  (coeff_idx),
    .acc_en     (acc_en),
    .acc_first  (acc_first),
    .acc_last   (acc_last),
    .strobe_out (strobe_out),
`ifdef HB_DECIM_SEQ_OVERRUN_EN
    .overrun_clr(overrun_clr),
    .overrun    (overrun),
`endif
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (cyc < LOGN) begin
      ae_log[cyc]   = acc_en;
      af_log[cyc]   = acc_first;
      al_log[cyc]   = acc_last;
      so_log[cyc]   = strobe_out;
      busy_log[cyc] = busy;
      cf_log[cyc]   = coeff_idx;
      r1_log[cyc]   = rd_addr1;
      r2_log[cyc]   = rd_addr2;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] d, output int c);
    strobe_in = 1'b1;
    data_in   = d;
    c         = cyc;
    tick();
    strobe_in = 1'b0;
    data_in   = '0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    strobe_in = 1'b0;
    data_in   = '0;
`ifdef HB_DECIM_SEQ_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    idle(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    logic [22:0] v;
    v = {write, wr_addr, rd_addr1, rd_addr2, coeff_idx,
         acc_en, acc_first, acc_last, strobe_out, busy};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
`ifdef HB_DECIM_SEQ_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_overrun: got %b want 0", overrun);
    end
`endif
  endtask

  task automatic test_write_path();
    int c;
    int first_c;
    int n;
    int trig[$];
    do_reset();
    first_c = cyc;
    for (int i = 0; i < 17; i++) begin
      strobe_in = 1'b1;
      data_in   = 16'(i + 1);
      c         = cyc;
      @(negedge clock);
      checks++;
      if (write !== 1'b1 || wr_addr !== 4'(i) || wr_data !== 16'(i + 1)) begin
        failures++;
        $display("FAIL write_path[%0d]: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                 i, write, wr_addr, wr_data, i % 16, i + 1);
      end
      @(posedge clock);
      #1;
      strobe_in = 1'b0;
      if (i % 2 == 1) trig.push_back(c);
      if (i < 16) idle(7);
    end
    idle(10);
    foreach (trig[j]) begin
      checks++;
      if (so_log[trig[j] + 8] !== 1'b1 || so_log[trig[j] + 7] !== 1'b0) begin
        failures++;
        $display("FAIL strobe_out_latency[%0d]: got at+7=%b at+8=%b want 0 1",
                 j, so_log[trig[j] + 7], so_log[trig[j] + 8]);
      end
    end
    n = 0;
    for (int k = first_c; k < cyc; k++) if (so_log[k] === 1'b1) n++;
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL strobe_out_count: got %0d want 8", n);
    end
  endtask

  task automatic test_single();
    int c;
    int t;
    int t0;
    logic [3:0] exp_r1[5] = '{4'd3, 4'd1, 4'd15, 4'd13, 4'd12};
    logic [3:0] exp_r2[5] = '{4'd5, 4'd7, 4'd9, 4'd11, 4'd12};
    do_reset();
    send(16'd10, c);
    send(16'd11, c);
    idle(10);
    send(16'd12, c);
    send(16'd13, t);
    idle(12);
    t0 = t + 1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (r1_log[t0 + k] !== exp_r1[k] || r2_log[t0 + k] !== exp_r2[k] ||
          busy_log[t0 + k] !== 1'b1) begin
        failures++;
        $display("FAIL rd_pair[%0d]: got (%0d,%0d) busy=%b want (%0d,%0d) busy=1",
                 k, r1_log[t0 + k], r2_log[t0 + k], busy_log[t0 + k], exp_r1[k], exp_r2[k]);
      end
      checks++;
      if (cf_log[t0 + 2 + k] !== 3'(k) || ae_log[t0 + 2 + k] !== 1'b1 ||
          af_log[t0 + 2 + k] !== (k == 0) || al_log[t0 + 2 + k] !== (k == 4)) begin
        failures++;
        $display("FAIL acc_ctrl[%0d]: got idx=%0d en=%b first=%b last=%b want idx=%0d en=1 first=%b last=%b",
                 k, cf_log[t0 + 2 + k], ae_log[t0 + 2 + k], af_log[t0 + 2 + k],
                 al_log[t0 + 2 + k], k, (k == 0), (k == 4));
      end
    end
    checks++;
    if (busy_log[t0 + 5] !== 1'b0 || busy_log[t] !== 1'b0) begin
      failures++;
      $display("FAIL busy_edges: got before=%b after=%b want 0 0", busy_log[t], busy_log[t0 + 5]);
    end
    checks++;
    if (ae_log[t0 + 1] !== 1'b0 || ae_log[t0 + 7] !== 1'b0 || cf_log[t0 + 7] !== 3'd0) begin
      failures++;
      $display("FAIL acc_en_edges: got pre=%b post=%b idx=%0d want 0 0 0",
               ae_log[t0 + 1], ae_log[t0 + 7], cf_log[t0 + 7]);
    end
    checks++;
    if (so_log[t0 + 6] !== 1'b0 || so_log[t0 + 7] !== 1'b1 || so_log[t0 + 8] !== 1'b0) begin
      failures++;
      $display("FAIL strobe_out_pulse: got %b%b%b want 010",
               so_log[t0 + 6], so_log[t0 + 7], so_log[t0 + 8]);
    end
    checks++;
    if (r1_log[t0 + 6] !== 4'd12 || r2_log[t0 + 6] !== 4'd12) begin
      failures++;
      $display("FAIL rd_hold_idle: got (%0d,%0d) want (12,12)", r1_log[t0 + 6], r2_log[t0 + 6]);
    end
  endtask

  task automatic test_overrun();
    int c0;
    int n;
    do_reset();
    c0 = cyc;
    strobe_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 16'(100 + i);
      tick();
    end
    strobe_in = 1'b0;
    idle(14);
    // Triggers at c0+1, c0+3, c0+5, c0+7: only c0+1 and c0+7 start sequences.
    n = 0;
    for (int k = c0; k < c0 + 21; k++) if (af_log[k] === 1'b1) n++;
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL overrun_seq_count: got %0d want 2", n);
    end
    checks++;
    if (af_log[c0 + 4] !== 1'b1 || af_log[c0 + 10] !== 1'b1) begin
      failures++;
      $display("FAIL overrun_first: got %b %b want 1 1", af_log[c0 + 4], af_log[c0 + 10]);
    end
    checks++;
    if (so_log[c0 + 9] !== 1'b1 || so_log[c0 + 15] !== 1'b1) begin
      failures++;
      $display("FAIL overrun_strobe: got %b %b want 1 1", so_log[c0 + 9], so_log[c0 + 15]);
    end
`ifdef HB_DECIM_SEQ_OVERRUN_EN
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr: got %b want 0", overrun);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int c;
    int t1;
    int t2;
    do_reset();
    send(16'd1, c);
    send(16'd2, t1);
    idle(3);
    send(16'd3, c);
    send(16'd4, t2);
    idle(14);
    checks++;
    if (t2 !== t1 + 5) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, 5);
    end
    for (int k = t1 + 3; k <= t1 + 12; k++) begin
      checks++;
      if (ae_log[k] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_acc_en[%0d]: got %b want 1", k - t1, ae_log[k]);
      end
    end
    checks++;
    if (ae_log[t1 + 2] !== 1'b0 || ae_log[t1 + 13] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_acc_en_edges: got %b %b want 0 0", ae_log[t1 + 2], ae_log[t1 + 13]);
    end
    checks++;
    if (af_log[t1 + 8] !== 1'b1 || al_log[t1 + 7] !== 1'b1 || al_log[t1 + 12] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_last: got first=%b last1=%b last2=%b want 1 1 1",
               af_log[t1 + 8], al_log[t1 + 7], al_log[t1 + 12]);
    end
    checks++;
    if (so_log[t1 + 8] !== 1'b1 || so_log[t1 + 13] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_strobe: got %b %b want 1 1", so_log[t1 + 8], so_log[t1 + 13]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cf_log[t1 + 8 + k] !== 3'(k)) begin
        failures++;
        $display("FAIL b2b_coeff[%0d]: got %0d want %0d", k, cf_log[t1 + 8 + k], k);
      end
    end
    // Second sequence: base 3, so the first pair is (3,5).
    checks++;
    if (r1_log[t2 + 1] !== 4'd3 || r2_log[t2 + 1] !== 4'd5 || busy_log[t2] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_base: got (%0d,%0d) busy=%b want (3,5) busy=1",
               r1_log[t2 + 1], r2_log[t2 + 1], busy_log[t2]);
    end
  endtask

  task automatic test_enable();
    int c;
    int t;
    int c1;
    int c2;
    int n;
    do_reset();
    send(16'd1, c);
    send(16'd2, t);
    send(16'd3, c);
    idle(1);
    enable = 1'b0;
    tick();
    strobe_in = 1'b1;
    data_in   = 16'd99;
    @(negedge clock);
    checks++;
    if (write !== 1'b0) begin
      failures++;
      $display("FAIL disabled_write: got %b want 0", write);
    end
    @(posedge clock);
    #1;
    strobe_in = 1'b0;
    data_in   = '0;
    idle(10);
    checks++;
    if (ae_log[t + 3] !== 1'b1 || busy_log[t + 3] !== 1'b1 || busy_log[t + 4] !== 1'b0) begin
      failures++;
      $display("FAIL disable_edge: got en=%b busy=%b%b want 1 10",
               ae_log[t + 3], busy_log[t + 3], busy_log[t + 4]);
    end
    n = 0;
    for (int k = t + 4; k <= t + 12; k++) if (ae_log[k] !== 1'b0) n++;
    for (int k = t; k <= t + 12; k++) if (so_log[k] !== 1'b0) n++;
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL disable_flush: got %0d active samples want 0", n);
    end
    enable = 1'b1;
    checks++;
    if (wr_addr !== 4'd3) begin
      failures++;
      $display("FAIL disable_ptr_held: got %0d want 3", wr_addr);
    end
    send(16'd4, c1);
    idle(8);
    checks++;
    if (busy_log[c1 + 1] !== 1'b0 || ae_log[c1 + 3] !== 1'b0) begin
      failures++;
      $display("FAIL reenable_phase0: got busy=%b en=%b want 0 0", busy_log[c1 + 1], ae_log[c1 + 3]);
    end
    send(16'd5, c2);
    idle(10);
    checks++;
    if (busy_log[c2 + 1] !== 1'b1 || so_log[c2 + 8] !== 1'b1 || r1_log[c2 + 1] !== 4'd4) begin
      failures++;
      $display("FAIL reenable_trigger: got busy=%b strobe=%b rd1=%0d want 1 1 4",
               busy_log[c2 + 1], so_log[c2 + 8], r1_log[c2 + 1]);
    end
  endtask

  task automatic test_async_reset();
    int c;
    int t;
    int n;
    logic [22:0] v;
    do_reset();
    send(16'd1, c);
    send(16'd2, t);
    idle(2);
    checks++;
    if (acc_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_active: got en=%b busy=%b want 1 1", acc_en, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    v = {write, wr_addr, rd_addr1, rd_addr2, coeff_idx,
         acc_en, acc_first, acc_last, strobe_out, busy};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h want 0", v);
    end
    idle(2);
    reset_n = 1'b1;
    idle(10);
    n = 0;
    for (int k = t + 4; k <= t + 14; k++) if (so_log[k] !== 1'b0 || busy_log[k] !== 1'b0) n++;
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL async_reset_no_strobe: got %0d active samples want 0", n);
    end
    send(16'd7, c);
    idle(2);
    checks++;
    if (busy_log[c + 1] !== 1'b0 || wr_addr !== 4'd1) begin
      failures++;
      $display("FAIL async_reset_state: got busy=%b ptr=%0d want 0 1", busy_log[c + 1], wr_addr);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    strobe_in = 1'b0;
    data_in   = '0;
`ifdef HB_DECIM_SEQ_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    idle(2);
    test_reset();
    test_write_path();
    test_single();
    test_overrun();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
